// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
// Control unit for a 5-stage MIPS32 pipeline. Decodes the ID-stage opcode
// into control flags and carries them through the ID/EX, EX/MEM and MEM/WB
// control registers. Detects load-use hazards, generates stall and IF/ID
// flush requests, and squashes ID/EX to a bubble on stalls and taken branches.
//
// Ports:
//   clk, rst          pipeline clock, synchronous active-high reset
//   id_opCode         opcode of the instruction in ID
//   id_rs, id_rt      source register fields of the instruction in ID
//   id_valid          ID holds a real instruction (0 = bubble)
//   ex_branch_taken   EX comparator result (qualified here by branch flags)
//   stall             hold PC and IF/ID (combinational)
//   flush_ifid        replace IF/ID with a bubble at the next edge
//   ex_*              ID/EX control outputs (ALU op, operand select, branch)
//   mem_*             EX/MEM control outputs
//   wb_*              MEM/WB control outputs (link = write PC+8 to $31)
//   stall_count       saturating count of stall cycles
module pipelined_control_unit #(
   parameter int EXT_ISA = 1,
   parameter int REG_W   = 5,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       id_opCode,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_valid,
   input  logic             ex_branch_taken,
   output logic             stall,
   output logic             flush_ifid,
   output logic [3:0]       ex_aluOp,
   output logic             ex_aluSrc,
   output logic             ex_regDest,
   output logic             ex_branch,
   output logic             ex_branchNe,
   output logic [REG_W-1:0] ex_rt_q,
   output logic             mem_memWrite,
   output logic             mem_memRead,
   output logic             wb_regWrite,
   output logic             wb_memtoReg,
   output logic             wb_link,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_FUNCT = 4'b0010;
   localparam logic [3:0] ALU_AND   = 4'b0011;
   localparam logic [3:0] ALU_OR    = 4'b0100;
   localparam logic [3:0] ALU_SLT   = 4'b0101;
   localparam logic [3:0] ALU_LUI   = 4'b0110;

   typedef struct packed {
      logic       reg_write;
      logic       reg_dest;
      logic       alu_src;
      logic       memto_reg;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       branch_ne;
      logic       jump;
      logic       link;
      logic [3:0] alu_op;
   } dec_t;

   // Jump is fully resolved in ID, so it is not carried into ID/EX.
   typedef struct packed {
      logic             reg_write;
      logic             reg_dest;
      logic             alu_src;
      logic             memto_reg;
      logic             mem_read;
      logic             mem_write;
      logic             branch;
      logic             branch_ne;
      logic             link;
      logic [3:0]       alu_op;
      logic [REG_W-1:0] rt;
   } idex_t;

   typedef struct packed {
      logic reg_write;
      logic memto_reg;
      logic mem_read;
      logic mem_write;
      logic link;
   } exmem_t;

   typedef struct packed {
      logic reg_write;
      logic memto_reg;
      logic link;
   } memwb_t;

   dec_t             dec;
   logic             known;
   logic             uses_rs;
   logic             uses_rt;
   logic             taken;
   logic             hazard;
   idex_t            idex_reg;
   exmem_t           exmem_reg;
   memwb_t           memwb_reg;
   logic [CNT_W-1:0] count_reg;

   // Opcode decode; unknown opcodes, extension opcodes without EXT_ISA and
   // invalid ID slots all decode to a bubble.
   always_comb begin
      dec     = '0;
      known   = 1'b0;
      uses_rt = 1'b0;
      if (id_valid) begin
         case (id_opCode)
            OP_LW: begin
               known = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
               dec.memto_reg = 1'b1; dec.mem_read = 1'b1; dec.alu_op = ALU_ADD;
            end
            OP_SW: begin
               known = 1'b1; uses_rt = 1'b1; dec.alu_src = 1'b1;
               dec.mem_write = 1'b1; dec.alu_op = ALU_ADD;
            end
            OP_R: begin
               known = 1'b1; uses_rt = 1'b1; dec.reg_write = 1'b1;
               dec.reg_dest = 1'b1; dec.alu_op = ALU_FUNCT;
            end
            OP_ADDI: begin
               known = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
               dec.alu_op = ALU_ADD;
            end
            OP_BEQ: begin
               known = 1'b1; uses_rt = 1'b1; dec.branch = 1'b1;
               dec.alu_op = ALU_SUB;
            end
            OP_J: begin
               known = 1'b1; dec.jump = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: begin
               if (EXT_ISA != 0) begin
                  known = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                  case (id_opCode)
                     OP_ANDI: dec.alu_op = ALU_AND;
                     OP_ORI:  dec.alu_op = ALU_OR;
                     OP_SLTI: dec.alu_op = ALU_SLT;
                     default: dec.alu_op = ALU_LUI;
                  endcase
               end
            end
            OP_BNE: begin
               if (EXT_ISA != 0) begin
                  known = 1'b1; uses_rt = 1'b1; dec.branch_ne = 1'b1;
                  dec.alu_op = ALU_SUB;
               end
            end
            OP_JAL: begin
               if (EXT_ISA != 0) begin
                  known = 1'b1; dec.jump = 1'b1; dec.reg_write = 1'b1;
                  dec.link = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Every real instruction except jumps reads rs.
   assign uses_rs = known & ~dec.jump;

   assign taken  = ex_branch_taken & (idex_reg.branch | idex_reg.branch_ne);
   assign hazard = idex_reg.mem_read && (idex_reg.rt != '0) &&
                   ((uses_rs && (idex_reg.rt == id_rs)) ||
                    (uses_rt && (idex_reg.rt == id_rt)));

   // Taken branch outranks the load-use stall; a jump flush yields to both.
   assign stall      = ~rst & hazard & ~taken;
   assign flush_ifid = ~rst & (taken | (dec.jump & ~stall));

   always_ff @(posedge clk) begin
      if (rst) begin
         idex_reg  <= '0;
         exmem_reg <= '0;
         memwb_reg <= '0;
         count_reg <= '0;
      end else begin
         if (taken || stall) begin
            idex_reg <= '0;
         end else begin
            idex_reg.reg_write <= dec.reg_write;
            idex_reg.reg_dest  <= dec.reg_dest;
            idex_reg.alu_src   <= dec.alu_src;
            idex_reg.memto_reg <= dec.memto_reg;
            idex_reg.mem_read  <= dec.mem_read;
            idex_reg.mem_write <= dec.mem_write;
            idex_reg.branch    <= dec.branch;
            idex_reg.branch_ne <= dec.branch_ne;
            idex_reg.link      <= dec.link;
            idex_reg.alu_op    <= dec.alu_op;
            idex_reg.rt        <= known ? id_rt : '0;
         end
         exmem_reg.reg_write <= idex_reg.reg_write;
         exmem_reg.memto_reg <= idex_reg.memto_reg;
         exmem_reg.mem_read  <= idex_reg.mem_read;
         exmem_reg.mem_write <= idex_reg.mem_write;
         exmem_reg.link      <= idex_reg.link;
         memwb_reg.reg_write <= exmem_reg.reg_write;
         memwb_reg.memto_reg <= exmem_reg.memto_reg;
         memwb_reg.link      <= exmem_reg.link;
         if (stall && (count_reg != '1)) begin
            count_reg <= count_reg + CNT_W'(1);
         end
      end
   end

   assign ex_aluOp     = idex_reg.alu_op;
   assign ex_aluSrc    = idex_reg.alu_src;
   assign ex_regDest   = idex_reg.reg_dest;
   assign ex_branch    = idex_reg.branch;
   assign ex_branchNe  = idex_reg.branch_ne;
   assign ex_rt_q      = idex_reg.rt;
   assign mem_memWrite = exmem_reg.mem_write;
   assign mem_memRead  = exmem_reg.mem_read;
   assign wb_regWrite  = memwb_reg.reg_write;
   assign wb_memtoReg  = memwb_reg.memto_reg;
   assign wb_link      = memwb_reg.link;
   assign stall_count  = count_reg;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: one instance with the extended ISA and
// one without, both on the same stimulus, compared each cycle against a
// table-driven model of the instruction set and pipeline.
module tb_pipelined_control_unit;

   localparam int CW = 5;
   localparam int CMAX = (1 << CW) - 1;

   logic       clk;
   logic       rst;
   logic [5:0] id_opCode;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_valid;
   logic       ex_branch_taken;

   logic          stall_o   [2];
   logic          flush_o   [2];
   logic [3:0]    aluop_o   [2];
   logic          alusrc_o  [2];
   logic          regdest_o [2];
   logic          br_o      [2];
   logic          bne_o     [2];
   logic [4:0]    rtq_o     [2];
   logic          mw_o      [2];
   logic          mr_o      [2];
   logic          rw_o      [2];
   logic          m2r_o     [2];
   logic          lk_o      [2];
   logic [CW-1:0] cnt_o     [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         pipelined_control_unit #(.EXT_ISA(gi), .REG_W(5), .CNT_W(CW)) dut (
            .clk(clk), .rst(rst), .id_opCode(id_opCode), .id_rs(id_rs),
            .id_rt(id_rt), .id_valid(id_valid),
            .ex_branch_taken(ex_branch_taken),
            .stall(stall_o[gi]), .flush_ifid(flush_o[gi]),
            .ex_aluOp(aluop_o[gi]), .ex_aluSrc(alusrc_o[gi]),
            .ex_regDest(regdest_o[gi]), .ex_branch(br_o[gi]),
            .ex_branchNe(bne_o[gi]), .ex_rt_q(rtq_o[gi]),
            .mem_memWrite(mw_o[gi]), .mem_memRead(mr_o[gi]),
            .wb_regWrite(rw_o[gi]), .wb_memtoReg(m2r_o[gi]),
            .wb_link(lk_o[gi]), .stall_count(cnt_o[gi])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction table: {opcode[22:17], flags[16:7], aluop[6:3], ext_only[2],
   // reads_rs[1], reads_rt[0]}. Flag order: regWrite regDest aluSrc memtoReg
   // memRead memWrite branch branchNe jump link.
   logic [22:0] tbl [12];

   typedef struct packed {
      logic       known;
      logic [9:0] f;
      logic [3:0] alu;
      logic       rs;
      logic       rt;
      logic [4:0] rtf;
   } ent_t;

   ent_t m_ex  [2];
   ent_t m_mem [2];
   ent_t m_wb  [2];
   int   m_cnt [2];
   logic m_stall1;
   int   checks;
   int   failures;
   int   cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t ref_dec(input logic [5:0] op, input logic v,
                                    input logic [4:0] rt, input bit ext);
      ent_t e;
      e = '0;
      if (v) begin
         for (int i = 0; i < 12; i++) begin
            if (tbl[i][22:17] == op && (!tbl[i][2] || ext)) begin
               e.known = 1'b1;
               e.f     = tbl[i][16:7];
               e.alu   = tbl[i][6:3];
               e.rs    = tbl[i][1];
               e.rt    = tbl[i][0];
               e.rtf   = rt;
            end
         end
      end
      return e;
   endfunction

   task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic v, input logic bt, input logic r);
      ent_t d;
      ent_t n_ex [2];
      ent_t n_mem [2];
      ent_t n_wb [2];
      int   n_cnt [2];
      logic tk, hz, es, ef;
      id_opCode = op; id_rs = rs; id_rt = rt; id_valid = v;
      ex_branch_taken = bt; rst = r;
      #4;
      for (int k = 0; k < 2; k++) begin
         d  = ref_dec(op, v, rt, k == 1);
         tk = bt && (m_ex[k].f[3] || m_ex[k].f[2]);
         hz = m_ex[k].f[5] && (m_ex[k].rtf != 5'd0) &&
              ((d.rs && m_ex[k].rtf == rs) || (d.rt && m_ex[k].rtf == rt));
         es = !r && hz && !tk;
         ef = !r && (tk || (d.f[1] && !es));
         check($sformatf("stall%0d@%0d", k, cyc), 32'(stall_o[k]), 32'(es));
         check($sformatf("flush%0d@%0d", k, cyc), 32'(flush_o[k]), 32'(ef));
         check($sformatf("ex%0d@%0d", k, cyc),
               32'({aluop_o[k], alusrc_o[k], regdest_o[k], br_o[k], bne_o[k], rtq_o[k]}),
               32'({m_ex[k].alu, m_ex[k].f[7], m_ex[k].f[8], m_ex[k].f[3], m_ex[k].f[2], m_ex[k].rtf}));
         check($sformatf("mem%0d@%0d", k, cyc), 32'({mw_o[k], mr_o[k]}),
               32'({m_mem[k].f[4], m_mem[k].f[5]}));
         check($sformatf("wb%0d@%0d", k, cyc), 32'({rw_o[k], m2r_o[k], lk_o[k]}),
               32'({m_wb[k].f[9], m_wb[k].f[6], m_wb[k].f[0]}));
         check($sformatf("cnt%0d@%0d", k, cyc), 32'(cnt_o[k]), 32'(m_cnt[k]));
         if (r) begin
            n_ex[k] = '0; n_mem[k] = '0; n_wb[k] = '0; n_cnt[k] = 0;
         end else begin
            n_ex[k]  = (tk || es) ? '0 : d;
            n_mem[k] = m_ex[k];
            n_wb[k]  = m_mem[k];
            n_cnt[k] = (es && m_cnt[k] < CMAX) ? m_cnt[k] + 1 : m_cnt[k];
         end
         if (k == 1) m_stall1 = es;
      end
      $display("cyc=%0d rst=%0d v=%0d op=%b rs=%0d rt=%0d bt=%0d stall=%0d/%0d flush=%0d/%0d cnt=%0d",
               cyc, r, v, op, rs, rt, bt, stall_o[1], stall_o[0], flush_o[1], flush_o[0], cnt_o[1]);
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         m_ex[k] = n_ex[k]; m_mem[k] = n_mem[k]; m_wb[k] = n_wb[k]; m_cnt[k] = n_cnt[k];
      end
      cyc++;
   endtask

   // Issue an instruction and keep it in ID while the extended-ISA unit stalls.
   task automatic issue(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
      int n;
      drive(op, rs, rt, 1'b1, 1'b0, 1'b0);
      n = 0;
      while (m_stall1 && n < 4) begin
         drive(op, rs, rt, 1'b1, 1'b0, 1'b0);
         n++;
      end
   endtask

   localparam logic [5:0] LW = 6'b100011, RT = 6'b000000, JMP = 6'b000010;
   localparam logic [5:0] BEQ = 6'b000100, JAL = 6'b000011, ADDI = 6'b001000;

   initial begin
      tbl[0]  = 23'b100011_1011100000_0000_0_1_0; // LW
      tbl[1]  = 23'b101011_0010010000_0000_0_1_1; // SW
      tbl[2]  = 23'b000000_1100000000_0010_0_1_1; // R
      tbl[3]  = 23'b001000_1010000000_0000_0_1_0; // ADDI
      tbl[4]  = 23'b000100_0000001000_0001_0_1_1; // BEQ
      tbl[5]  = 23'b000010_0000000010_0000_0_0_0; // J
      tbl[6]  = 23'b001100_1010000000_0011_1_1_0; // ANDI
      tbl[7]  = 23'b001101_1010000000_0100_1_1_0; // ORI
      tbl[8]  = 23'b001010_1010000000_0101_1_1_0; // SLTI
      tbl[9]  = 23'b001111_1010000000_0110_1_1_0; // LUI
      tbl[10] = 23'b000101_0000000100_0001_1_1_1; // BNE
      tbl[11] = 23'b000011_1000000011_0000_1_0_0; // JAL
      checks = 0; failures = 0; cyc = 0; m_stall1 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_cnt[k] = 0;
      end

      // Reset with a load in ID.
      rst = 1'b1; id_opCode = LW; id_rs = 5'd1; id_rt = 5'd8;
      id_valid = 1'b1; ex_branch_taken = 1'b0;
      @(posedge clk);
      #1;
      drive(LW, 5'd1, 5'd8, 1'b1, 1'b0, 1'b1);
      drive(LW, 5'd1, 5'd8, 1'b1, 1'b0, 1'b1);

      // Load-use on rs: one stall cycle, then the ADD proceeds.
      issue(LW, 5'd1, 5'd8);
      issue(RT, 5'd8, 5'd2);
      repeat (3) drive(6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

      // Jump whose fields match the load target, then a load to $0.
      issue(LW, 5'd1, 5'd8);
      issue(JMP, 5'd8, 5'd8);
      issue(LW, 5'd1, 5'd0);
      issue(RT, 5'd0, 5'd0);

      // Taken BEQ in EX while a dependent op sits in ID.
      issue(BEQ, 5'd3, 5'd4);
      drive(RT, 5'd4, 5'd3, 1'b1, 1'b1, 1'b0);
      drive(ADDI, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);

      // JAL through to write-back.
      issue(JAL, 5'd0, 5'd0);
      repeat (4) drive(6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

      // Reset while a stall is pending.
      issue(LW, 5'd1, 5'd8);
      drive(RT, 5'd8, 5'd1, 1'b1, 1'b0, 1'b1);
      drive(RT, 5'd8, 5'd1, 1'b1, 1'b0, 1'b0);

      // A self-dependent load held in ID stalls every other cycle; well past
      // the counter range to exercise saturation.
      repeat (80) drive(LW, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0);

      // Randomized traffic over a small register range to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         logic [5:0] op;
         logic [4:0] idx;
         idx = 5'($urandom_range(0, 11));
         op  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : tbl[idx][22:17];
         drive(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 7) != 0), 1'($urandom),
               1'($urandom_range(0, 49) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
